// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side master for the simple dual-port RAM (port B).
// A start command sweeps base..base+len-1 with wrap-around. The block absorbs
// the RAM's one-cycle read latency and presents the words as a valid/ready
// stream through a two-entry output buffer (head register + skid register).
module ram_stream_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] addr_b_o,
  input  logic [DATA_W-1:0] data_b_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_cnt;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;

  // Output buffer: head entry drives the stream, skid entry holds the second word.
  logic              r_h_valid;
  logic [DATA_W-1:0] r_h_data;
  logic              r_h_last;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic              r_s_last;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ_after;
  logic              w_issue;
  logic              w_issue_last;

  // Occupancy after this edge (pop + capture) decides whether another address may go out;
  // this bounds buffer plus in-flight words to two, so nothing is ever dropped.
  always_comb begin
    w_pop        = r_h_valid & m_ready_i;
    w_push       = r_inflight;
    w_occ_after  = {2'b00, r_h_valid} + {2'b00, r_s_valid}
                 - {2'b00, w_pop} + {2'b00, w_push};
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    if (r_state == S_READ) begin
      w_issue      = (w_occ_after < 3'd2);
      w_issue_last = w_issue && (r_issue_cnt == {{ADDR_W{1'b0}}, 1'b1});
    end else begin
      w_issue      = 1'b0;
      w_issue_last = 1'b0;
    end
  end

  // Command FSM: accepts start in IDLE, walks the address, reports completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_issue_cnt <= {(ADDR_W+1){1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            if (len_i != {(ADDR_W+1){1'b0}}) begin
              r_state     <= S_READ;
              r_addr      <= base_addr_i;
              r_issue_cnt <= len_i;
              r_busy      <= 1'b1;
            end else begin
              // Empty command: completion is reported at once, busy covers that cycle.
              r_state <= S_DONE;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_issue_cnt <= r_issue_cnt - {{ADDR_W{1'b0}}, 1'b1};
            if (w_issue_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_READ;
            end
          end else begin
            r_state <= S_READ;
          end
        end
        S_DRAIN: begin
          if (w_occ_after == 3'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // In-flight tracker: an issued address returns its word exactly one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
    end
  end

  // Output buffer: pop from head, shift skid forward, capture returning word into the first free slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h_valid <= 1'b0;
      r_h_data  <= {DATA_W{1'b0}};
      r_h_last  <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_data  <= {DATA_W{1'b0}};
      r_s_last  <= 1'b0;
    end else begin
      if (w_pop) begin
        if (r_s_valid) begin
          r_h_valid <= 1'b1;
          r_h_data  <= r_s_data;
          r_h_last  <= r_s_last;
          r_s_valid <= w_push;
          if (w_push) begin
            r_s_data <= data_b_i;
            r_s_last <= r_inflight_last;
          end else begin
            r_s_last <= 1'b0;
          end
        end else begin
          r_h_valid <= w_push;
          if (w_push) begin
            r_h_data <= data_b_i;
            r_h_last <= r_inflight_last;
          end else begin
            r_h_last <= 1'b0;
          end
          r_s_valid <= 1'b0;
        end
      end else begin
        if (r_h_valid) begin
          // Head is stalled and must stay stable; a returning word goes to the skid slot.
          if (w_push) begin
            r_s_valid <= 1'b1;
            r_s_data  <= data_b_i;
            r_s_last  <= r_inflight_last;
          end else begin
            r_s_valid <= r_s_valid;
          end
        end else begin
          if (w_push) begin
            r_h_valid <= 1'b1;
            r_h_data  <= data_b_i;
            r_h_last  <= r_inflight_last;
          end else begin
            r_h_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign addr_b_o  = r_addr;
  assign m_valid_o = r_h_valid;
  assign m_data_o  = r_h_data;
  assign m_last_o  = r_h_last;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: the stimulus process pushes the
// hand-computed expected words; a negedge monitor pops and compares each
// word the DUT hands over, and checks stability while the consumer stalls.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] base = 2'd0;
  logic [2:0] len = 3'd0;
  logic [1:0] addr_b;
  logic [0:0] ram_q = 1'b0;
  logic       m_valid;
  logic [0:0] m_data;
  logic       m_last;
  logic       rdy = 1'b1;
  logic       busy;
  logic       done;

  logic [0:0] mem [0:3];

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  // expected entry: {data, last}
  logic [1:0] exp_q [$];

  logic       stall_vld = 1'b0;
  logic [0:0] stall_data = 1'b0;
  logic       stall_last = 1'b0;

  ram_stream_reader #(.ADDR_W(2), .DATA_W(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
    .addr_b_o(addr_b), .data_b_i(ram_q), .m_valid_o(m_valid), .m_data_o(m_data),
    .m_last_o(m_last), .m_ready_i(rdy), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // RAM port B model: registered read.
  always @(posedge clk) ram_q <= mem[addr_b];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a word counts as transferred when valid&&ready ahead of the next edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst) begin
      stall_vld = 1'b0;
    end else begin
      if (stall_vld) begin
        chk("stall_valid_held", int'(m_valid), 1);
        chk("stall_data_stable", int'(m_data), int'(stall_data));
        chk("stall_last_stable", int'(m_last), int'(stall_last));
      end
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", int'(m_data), int'(e[1]));
          chk("word_last", int'(m_last), int'(e[0]));
          xfers++;
        end
      end
      stall_vld  = m_valid && !rdy;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic issue(input logic [1:0] b, input logic [2:0] l);
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int seen;
    logic [6:0] pat;
    pat = 7'b1101001;
    mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", int'(addr_b), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1; rst = 1'b0;

    // T1: base 0, len 4, ready high
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    x0 = xfers;
    issue(2'd0, 3'd4);
    @(negedge clk);                       // after accept edge
    chk("t1_busy", int'(busy), 1);
    chk("t1_addr0", int'(addr_b), 0);
    chk("t1_valid_e0", int'(m_valid), 0);
    @(negedge clk);                       // 1 edge after accept
    chk("t1_valid_e1", int'(m_valid), 0);
    chk("t1_addr1", int'(addr_b), 1);
    @(negedge clk);                       // 2 edges after accept
    chk("t1_valid_e2", int'(m_valid), 1);
    chk("t1_last_w1", int'(m_last), 0);
    @(negedge clk);
    chk("t1_valid_e3", int'(m_valid), 1);
    @(negedge clk);
    chk("t1_valid_e4", int'(m_valid), 1);
    @(negedge clk);
    chk("t1_valid_e5", int'(m_valid), 1);
    chk("t1_last_w4", int'(m_last), 1);
    @(negedge clk);
    chk("t1_done", int'(done), 1);
    chk("t1_busy_done", int'(busy), 0);
    chk("t1_valid_after", int'(m_valid), 0);
    @(negedge clk);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_xfers", xfers - x0, 4);

    // T2: base 3, len 3, wrap-around
    exp_q.push_back(2'b10); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    x0 = xfers;
    issue(2'd3, 3'd3);
    @(negedge clk);
    chk("t2_addr_a", int'(addr_b), 3);
    @(negedge clk);
    chk("t2_addr_b", int'(addr_b), 0);
    @(negedge clk);
    chk("t2_addr_c", int'(addr_b), 1);
    wait_done("t2_done", 20);
    chk("t2_xfers", xfers - x0, 3);
    chk("t2_q_empty", exp_q.size(), 0);

    // T3: backpressure pattern 1,0,0,1,0,1,1,...
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    x0 = xfers;
    seen = 0;
    issue(2'd0, 3'd4);
    for (int i = 0; i < 40 && seen == 0; i++) begin
      rdy = (i < 7) ? pat[i] : 1'b1;
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    chk("t3_done", seen, 1);
    chk("t3_xfers", xfers - x0, 4);
    chk("t3_q_empty", exp_q.size(), 0);

    // T4: zero-length command
    x0 = xfers;
    issue(2'd1, 3'd0);
    @(negedge clk);
    chk("t4_busy", int'(busy), 1);
    chk("t4_done", int'(done), 1);
    chk("t4_valid", int'(m_valid), 0);
    @(negedge clk);
    chk("t4_busy_after", int'(busy), 0);
    chk("t4_done_after", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("t4_xfers", xfers - x0, 0);

    // T5: asynchronous reset after the 2nd transfer, then a fresh command
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    x0 = xfers;
    issue(2'd0, 3'd4);                    // returns at accept edge + 1
    repeat (4) @(posedge clk);            // edge carrying the 2nd transfer
    #2;
    chk("t5_xfers_before_rst", xfers - x0, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", int'(m_valid), 0);
    chk("t5_rst_data", int'(m_data), 0);
    chk("t5_rst_last", int'(m_last), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_addr", int'(addr_b), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || m_valid) seen = 1;
    end
    chk("t5_quiet_after_rst", seen, 0);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    x0 = xfers;
    issue(2'd2, 3'd2);
    wait_done("t5_done", 20);
    chk("t5_xfers", xfers - x0, 2);

    // T6: start while busy is ignored
    exp_q.push_back(2'b10); exp_q.push_back(2'b00);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    x0 = xfers;
    issue(2'd0, 3'd4);
    start = 1'b1; base = 2'd1; len = 3'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6_done", 20);
    chk("t6_xfers", xfers - x0, 4);
    chk("t6_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_requeue_busy", int'(busy), 0);
    chk("t6_no_requeue_valid", int'(m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
